// File: rtl/bwdfwd_pipe_n.sv
// rtl/bwdfwd_pipe_n.sv - cascade of skid-buffered register slices with registered occupancy
module bwdfwd_pipe_n #(
    parameter int DATA_W = 256,
    parameter int STAGES = 2,
    localparam int CNT_W = (STAGES == 0) ? 1 : $clog2(2*STAGES+1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              f_valid_in,
    input  logic [DATA_W-1:0] f_data_in,
    output logic              f_ready_out,
    output logic              b_valid_out,
    output logic [DATA_W-1:0] b_data_out,
    input  logic              b_ready_in,
    output logic [CNT_W-1:0]  occupancy
);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} slice_state_t;

    if (STAGES == 0) begin : g_pass
        logic w_unused;
        assign w_unused    = ^{flush, clk, rst_n};
        assign f_ready_out = b_ready_in;
        assign b_valid_out = f_valid_in;
        assign b_data_out  = f_data_in;
        assign occupancy   = '0;
    end else begin : g_pipe
        // Index k is the input side of slice k; index k+1 is its output side.
        logic [STAGES:0]   w_valid;
        logic [STAGES:0]   w_ready;
        logic [DATA_W-1:0] w_data [0:STAGES];
        logic              w_up;
        logic              w_dn;
        logic [CNT_W-1:0]  r_occ;

        assign w_valid[0]      = f_valid_in;
        assign w_data[0]       = f_data_in;
        assign f_ready_out     = w_ready[0];
        assign w_ready[STAGES] = b_ready_in;
        assign b_valid_out     = w_valid[STAGES];
        assign b_data_out      = w_data[STAGES];

        for (genvar k = 0; k < STAGES; k++) begin : g_slice
            slice_state_t      r_state;
            slice_state_t      w_state_nxt;
            logic [DATA_W-1:0] r_main;
            logic [DATA_W-1:0] r_skid;
            logic [DATA_W-1:0] w_main_nxt;
            logic [DATA_W-1:0] w_skid_nxt;
            logic              w_in;
            logic              w_out;

            assign w_in  = w_valid[k] & w_ready[k];
            assign w_out = w_valid[k+1] & w_ready[k+1];

            always_comb begin
                w_state_nxt = r_state;
                w_main_nxt  = r_main;
                w_skid_nxt  = r_skid;
                case (r_state)
                    S_EMPTY: begin
                        if (w_in) begin
                            w_state_nxt = S_ONE;
                            w_main_nxt  = w_data[k];
                        end
                    end
                    S_ONE: begin
                        if (w_in && w_out) begin
                            w_main_nxt  = w_data[k];
                        end else if (w_in) begin
                            w_state_nxt = S_TWO;
                            w_skid_nxt  = w_data[k];
                        end else if (w_out) begin
                            w_state_nxt = S_EMPTY;
                        end
                    end
                    S_TWO: begin
                        if (w_out) begin
                            w_state_nxt = S_ONE;
                            w_main_nxt  = r_skid;
                        end
                    end
                    default: w_state_nxt = S_EMPTY;
                endcase
                if (flush) begin
                    w_state_nxt = S_EMPTY;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state <= S_EMPTY;
                    r_main  <= '0;
                    r_skid  <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_main  <= w_main_nxt;
                    r_skid  <= w_skid_nxt;
                end
            end

            // Handshake outputs come from registered state only.
            assign w_valid[k+1] = (r_state != S_EMPTY);
            assign w_ready[k]   = (r_state != S_TWO);
            assign w_data[k+1]  = r_main;
        end

        assign w_up = f_valid_in & f_ready_out;
        assign w_dn = b_valid_out & b_ready_in;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_occ <= '0;
            end else if (flush) begin
                r_occ <= '0;
            end else if (w_up && !w_dn) begin
                r_occ <= r_occ + CNT_W'(1);
            end else if (w_dn && !w_up) begin
                r_occ <= r_occ - CNT_W'(1);
            end
        end

        assign occupancy = r_occ;
    end

endmodule

// File: doc/bwdfwd_pipe_n.md
BWDFWD_PIPE_N -- requirements
Module: bwdfwd_pipe_n

Interface
- REQ-001: Parameter DATA_W, default 256, payload width in bits.
- REQ-002: Parameter STAGES, default 2, number of cascaded register slices; legal range 0..16.
- REQ-003: Derived localparam CNT_W = $clog2(2*STAGES+1), minimum 1; width of occupancy.
- REQ-004: clk  input  1  single clock; all state updates on rising edge.
- REQ-005: rst_n  input  1  reset, asynchronous, active-low.
- REQ-006: flush  input  1  synchronous clear of all buffered beats.
- REQ-007: f_valid_in  input  1  upstream beat valid.
- REQ-008: f_data_in  input  DATA_W  upstream payload.
- REQ-009: f_ready_out  output  1  block can accept a beat.
- REQ-010: b_valid_out  output  1  downstream beat valid.
- REQ-011: b_data_out  output  DATA_W  downstream payload.
- REQ-012: b_ready_in  input  1  downstream accepts beat.
- REQ-013: occupancy  output  CNT_W  count of beats currently held, 0..2*STAGES.

Function
- REQ-014: Transfer occurs on an edge where valid and ready are both high; upstream side is f_valid_in & f_ready_out, downstream side is b_valid_out & b_ready_in.
- REQ-015: Each slice holds a main register and a skid register and has states EMPTY, ONE and TWO.
- REQ-016: A slice drives valid = (state != EMPTY) and ready = (state != TWO), both decoded from registered state only, so no combinational path runs from b_ready_in to f_ready_out or from f_valid_in to b_valid_out.
- REQ-017: Slice transitions:
  - EMPTY+in -> ONE, with data loaded into main.
  - ONE+in&!out -> TWO, with data loaded into skid.
  - ONE+out&!in -> EMPTY.
  - ONE+in&out -> ONE, with main reloaded.
  - TWO+out -> ONE, with skid moved to main.
  - Any other combination holds state.
- REQ-018: In state TWO the slice deasserts ready, so simultaneous in and out in TWO cannot occur.
- REQ-019: Slice k's output feeds slice k+1's input; slice 0 connects to the f_* ports, and slice STAGES-1 connects to the b_* ports.
- REQ-020: Beat order is preserved exactly, with no loss or duplication except under flush.
- REQ-021: With b_ready_in held high, a beat accepted at edge t is presented on b_valid_out/b_data_out in the cycle after edge t+STAGES-1, i.e. the latency is STAGES cycles.
- REQ-022: Sustained throughput is one beat per cycle when b_ready_in is held high.
- REQ-023: Under continuous backpressure the block accepts exactly 2*STAGES beats before f_ready_out falls.
- REQ-024: occupancy equals the sum over slices of entries held (EMPTY=0, ONE=1, TWO=2) and is registered, updated on the same edge as the state change.
- REQ-025: occupancy is incremented on an upstream transfer, decremented on a downstream transfer, and unchanged when both or neither occur.
- REQ-026: flush=1 at an edge forces every slice to EMPTY and occupancy to 0; any transfer in that cycle on either side is discarded, and flush has priority over all transitions.
- REQ-027: While flush is high, f_ready_out and b_valid_out follow state as normal; the clear takes effect at the edge.
- REQ-028: STAGES=0 is a combinational pass-through:
  - f_ready_out = b_ready_in, b_valid_out = f_valid_in and b_data_out = f_data_in.
  - occupancy is tied to 0 and flush is ignored.
- REQ-029: b_data_out reflects the main register of the last slice and holds stable while b_valid_out=1 and b_ready_in=0.

Reset
- REQ-030: While rst_n=0, all slices are EMPTY and all data registers are 0, giving b_valid_out=0, b_data_out=0, f_ready_out=1 and occupancy=0.
- REQ-031: Assertion of rst_n mid-transfer clears state immediately and asynchronously; in-flight beats are lost.
- REQ-032: The first transfer is possible on the first rising edge after rst_n deasserts.

Verification (DATA_W=8, STAGES=2 unless noted)
- REQ-033: Reset check: hold rst_n=0 -> b_valid_out=0, b_data_out=0x00, f_ready_out=1, occupancy=0.
- REQ-034: Streaming check:
  - Stimulus: b_ready_in=1, beats 0x01..0x10 pushed back-to-back.
  - Response: 0x01 appears 2 cycles after acceptance, then one beat per cycle in order, f_ready_out stays 1, occupancy stays 2.
- REQ-035: Backpressure check:
  - Stimulus: b_ready_in=0, f_valid_in=1 continuously.
  - Response: exactly 4 beats accepted, f_ready_out=0, occupancy=4.
  - Stimulus: then raise b_ready_in.
  - Response: outputs 0x01,0x02,0x03,0x04 in order.
- REQ-036: Random-stall check:
  - Stimulus: random f_valid_in/b_ready_in, 1000 beats.
  - Response: scoreboard shows order preserved, no drops, b_data_out stable under stall, occupancy always equals accepted minus delivered.
- REQ-037: Flush check:
  - Stimulus: occupancy=3, then flush=1 with f_valid_in=1 and b_ready_in=1 in the same cycle.
  - Response: next cycle occupancy=0, b_valid_out=0, f_ready_out=1; neither beat is counted.
- REQ-038: Pass-through check:
  - Stimulus: STAGES=0, toggle b_ready_in.
  - Response: f_ready_out mirrors b_ready_in in the same cycle, b_data_out equals f_data_in, occupancy=0.
